// File: rtl/phy_idelay_pkg.sv
// rtl/phy_idelay_pkg.sv - shared types and constants for the RGMII RX IDELAY tap scan
package phy_idelay_pkg;

  localparam int TAP_W = 5;
  localparam logic [TAP_W-1:0] TAP_MAX = 5'd31;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_RDY,
    ST_LOAD,
    ST_SETTLE,
    ST_CHECK,
    ST_STEP,
    ST_EVAL,
    ST_APPLY_LD,
    ST_APPLY_INC,
    ST_VERIFY,
    ST_DONE
  } tap_scan_state_e;

  typedef enum logic [1:0] {
    CK_SKIP,
    CK_IDLE,
    CK_PRE,
    CK_DONE
  } chk_state_e;

  // Centre of a window, rounded down for even lengths.
  function automatic logic [TAP_W-1:0] centre_of(input logic [5:0] start, input logic [5:0] len);
    logic [5:0] c;
    c = start + ((len - 6'd1) >> 1);
    return c[TAP_W-1:0];
  endfunction

endpackage

// File: rtl/phy_idelay_tap_scan_if.sv
// rtl/phy_idelay_tap_scan_if.sv - IDELAY control/readback and RX byte path bundle
interface phy_idelay_tap_scan_if;
  import phy_idelay_pkg::*;

  logic             idelay_ld_out;
  logic             idelay_ce_out;
  logic             idelay_inc_out;
  logic [TAP_W-1:0] idelay_counter_value_in;
  logic [7:0]       phy_rxd_in;
  logic             phy_rvalid_in;

  modport master (
    output idelay_ld_out,
    output idelay_ce_out,
    output idelay_inc_out,
    input  idelay_counter_value_in,
    input  phy_rxd_in,
    input  phy_rvalid_in
  );

  modport slave (
    input  idelay_ld_out,
    input  idelay_ce_out,
    input  idelay_inc_out,
    output idelay_counter_value_in,
    output phy_rxd_in,
    output phy_rvalid_in
  );

endinterface

// File: rtl/phy_preamble_checker.sv
// rtl/phy_preamble_checker.sv - preamble/SFD frame qualifier, one good/bad pulse per frame while armed
module phy_preamble_checker
  import phy_idelay_pkg::*;
#(
  parameter int MIN_PRE = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm_in,
  input  logic [7:0] rxd_in,
  input  logic       rvalid_in,
  output logic       good_out,
  output logic       bad_out
);

  chk_state_e  st_q, st_d;
  logic [3:0]  pre_q, pre_d;
  logic        rvalid_prev_q, rvalid_prev_d;
  logic        take_byte;
  logic [3:0]  pre_base;

  always_comb begin
    st_d          = st_q;
    pre_d         = pre_q;
    rvalid_prev_d = rvalid_in;
    good_out      = 1'b0;
    bad_out       = 1'b0;
    take_byte     = 1'b0;
    pre_base      = pre_q;

    if (!arm_in) begin
      // Disarmed: any frame seen on re-arm counts as already in flight.
      st_d  = CK_SKIP;
      pre_d = 4'd0;
    end else begin
      case (st_q)
        CK_SKIP, CK_IDLE: begin
          if (rvalid_in && !rvalid_prev_q) begin
            take_byte = 1'b1;
            pre_base  = 4'd0;
          end else if (!rvalid_in) begin
            st_d = CK_IDLE;
          end
        end
        CK_PRE: begin
          if (!rvalid_in) begin
            bad_out = 1'b1;
            st_d    = CK_IDLE;
          end else begin
            take_byte = 1'b1;
          end
        end
        CK_DONE: begin
          if (!rvalid_in) st_d = CK_IDLE;
        end
      endcase

      if (take_byte) begin
        if (rxd_in == PRE_BYTE) begin
          pre_d = (pre_base == 4'd15) ? 4'd15 : pre_base + 4'd1;
          st_d  = CK_PRE;
        end else if (rxd_in == SFD_BYTE && int'(pre_base) >= MIN_PRE) begin
          good_out = 1'b1;
          st_d     = CK_DONE;
        end else begin
          bad_out = 1'b1;
          st_d    = CK_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= CK_SKIP;
      pre_q         <= 4'd0;
      rvalid_prev_q <= 1'b0;
    end else begin
      st_q          <= st_d;
      pre_q         <= pre_d;
      rvalid_prev_q <= rvalid_prev_d;
    end
  end

endmodule

// File: rtl/phy_idelay_tap_scan.sv
// rtl/phy_idelay_tap_scan.sv - sweeps IDELAY taps 0..31, finds the longest passing window, applies its centre
module phy_idelay_tap_scan
  import phy_idelay_pkg::*;
#(
  parameter int GOOD_FRAMES   = 4,
  parameter int MIN_PRE       = 6,
  parameter int SETTLE_CYCLES = 16,
  parameter int TIMEOUT_W     = 16
) (
  input  logic                 phy_rx_clk,
  input  logic                 sys_rst,
  input  logic                 train_start_in,
  input  logic                 idelayctrl_rdy_in,
  phy_idelay_tap_scan_if.master phy_if,
  output logic                 train_busy_out,
  output logic                 train_done_out,
  output logic                 train_fail_out,
  output logic [TAP_W-1:0]     tap_value_out,
  output logic [5:0]           window_len_out
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int GF_W  = $clog2(GOOD_FRAMES + 1);
  localparam logic [SET_W-1:0]     SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [GF_W-1:0]      GF_LAST  = GF_W'(GOOD_FRAMES - 1);
  // Verdict lands in the (2^W-1)th CHECK cycle; the counter is 0 in the first.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

  tap_scan_state_e      state_q, state_d;
  logic [SET_W-1:0]     set_cnt_q, set_cnt_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [GF_W-1:0]      good_cnt_q, good_cnt_d;
  logic [TAP_W-1:0]     tap_q, tap_d;
  logic [5:0]           run_start_q, run_start_d;
  logic [5:0]           run_len_q, run_len_d;
  logic [5:0]           best_start_q, best_start_d;
  logic [5:0]           best_len_q, best_len_d;
  logic [TAP_W-1:0]     centre_q, centre_d;
  logic [TAP_W-1:0]     inc_cnt_q, inc_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [TAP_W-1:0]     tap_out_q, tap_out_d;
  logic [5:0]           wlen_q, wlen_d;

  logic       ld_o, ce_o;
  logic       arm, good_v, bad_v;
  logic       pass_hit, fail_hit, verdict;
  logic [5:0] tap6, cur_start, cur_len, cand_start, cand_len;
  logic       busy_state;

  phy_preamble_checker #(
    .MIN_PRE (MIN_PRE)
  ) u_chk (
    .clk       (phy_rx_clk),
    .rst_n     (sys_rst),
    .arm_in    (arm),
    .rxd_in    (phy_if.phy_rxd_in),
    .rvalid_in (phy_if.phy_rvalid_in),
    .good_out  (good_v),
    .bad_out   (bad_v)
  );

  assign arm        = (state_q == ST_CHECK);
  assign pass_hit   = good_v && (good_cnt_q == GF_LAST);
  assign fail_hit   = bad_v || (tmo_q == TMO_LAST);
  assign verdict    = arm && (pass_hit || fail_hit);
  assign busy_state = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign tap6       = {1'b0, tap_q};
  assign cur_start  = (run_len_q == 6'd0) ? tap6 : run_start_q;
  assign cur_len    = run_len_q + 6'd1;

  always_comb begin
    state_d      = state_q;
    set_cnt_d    = set_cnt_q;
    tmo_d        = tmo_q;
    good_cnt_d   = good_cnt_q;
    tap_d        = tap_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    centre_d     = centre_q;
    inc_cnt_d    = inc_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    tap_out_d    = tap_out_q;
    wlen_d       = wlen_q;
    ld_o         = 1'b0;
    ce_o         = 1'b0;
    cand_start   = 6'd0;
    cand_len     = 6'd0;

    if (busy_state && !idelayctrl_rdy_in) begin
      state_d      = ST_WAIT_RDY;
      tap_d        = '0;
      good_cnt_d   = '0;
      run_start_d  = 6'd0;
      run_len_d    = 6'd0;
      best_start_d = 6'd0;
      best_len_d   = 6'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (train_start_in) begin
            state_d      = ST_WAIT_RDY;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            fail_d       = 1'b0;
            tap_out_d    = '0;
            wlen_d       = 6'd0;
            tap_d        = '0;
            good_cnt_d   = '0;
            run_start_d  = 6'd0;
            run_len_d    = 6'd0;
            best_start_d = 6'd0;
            best_len_d   = 6'd0;
          end
        end
        ST_WAIT_RDY: state_d = ST_LOAD;
        ST_LOAD: begin
          ld_o      = 1'b1;
          tap_d     = '0;
          set_cnt_d = '0;
          state_d   = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (set_cnt_q == SET_LAST) begin
            if (phy_if.idelay_counter_value_in != tap_q) begin
              fail_d  = 1'b1;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_DONE;
            end else begin
              tmo_d      = '0;
              good_cnt_d = '0;
              state_d    = ST_CHECK;
            end
          end else begin
            set_cnt_d = set_cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          tmo_d = tmo_q + 1'b1;
          if (good_v) good_cnt_d = good_cnt_q + 1'b1;
          if (verdict) begin
            if (pass_hit) begin
              run_start_d = cur_start;
              run_len_d   = cur_len;
              cand_start  = cur_start;
              cand_len    = cur_len;
            end else begin
              run_len_d  = 6'd0;
              cand_start = run_start_q;
              cand_len   = run_len_q;
            end
            // Strictly longer only, so the lower-start window wins a tie.
            if ((!pass_hit || tap_q == TAP_MAX) && cand_len > best_len_q) begin
              best_start_d = cand_start;
              best_len_d   = cand_len;
            end
            state_d = (tap_q == TAP_MAX) ? ST_EVAL : ST_STEP;
          end
        end
        ST_STEP: begin
          ce_o      = 1'b1;
          tap_d     = tap_q + 1'b1;
          set_cnt_d = '0;
          state_d   = ST_SETTLE;
        end
        ST_EVAL: begin
          if (best_len_q == 6'd0) begin
            fail_d    = 1'b1;
            centre_d  = '0;
            tap_out_d = '0;
            wlen_d    = 6'd0;
          end else begin
            centre_d  = centre_of(best_start_q, best_len_q);
            tap_out_d = centre_of(best_start_q, best_len_q);
            wlen_d    = best_len_q;
          end
          state_d = ST_APPLY_LD;
        end
        ST_APPLY_LD: begin
          ld_o      = 1'b1;
          inc_cnt_d = '0;
          state_d   = ST_APPLY_INC;
        end
        ST_APPLY_INC: begin
          if (inc_cnt_q == centre_q) begin
            set_cnt_d = '0;
            state_d   = ST_VERIFY;
          end else begin
            ce_o      = 1'b1;
            inc_cnt_d = inc_cnt_q + 1'b1;
          end
        end
        ST_VERIFY: begin
          if (set_cnt_q == SET_LAST) begin
            if (phy_if.idelay_counter_value_in != centre_q) fail_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            set_cnt_d = set_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge phy_rx_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= ST_IDLE;
      set_cnt_q    <= '0;
      tmo_q        <= '0;
      good_cnt_q   <= '0;
      tap_q        <= '0;
      run_start_q  <= 6'd0;
      run_len_q    <= 6'd0;
      best_start_q <= 6'd0;
      best_len_q   <= 6'd0;
      centre_q     <= '0;
      inc_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      tap_out_q    <= '0;
      wlen_q       <= 6'd0;
    end else begin
      state_q      <= state_d;
      set_cnt_q    <= set_cnt_d;
      tmo_q        <= tmo_d;
      good_cnt_q   <= good_cnt_d;
      tap_q        <= tap_d;
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      centre_q     <= centre_d;
      inc_cnt_q    <= inc_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      tap_out_q    <= tap_out_d;
      wlen_q       <= wlen_d;
    end
  end

  assign phy_if.idelay_ld_out  = ld_o;
  assign phy_if.idelay_ce_out  = ce_o;
  assign phy_if.idelay_inc_out = ce_o;
  assign train_busy_out        = busy_q;
  assign train_done_out        = done_q;
  assign train_fail_out        = fail_q;
  assign tap_value_out         = tap_out_q;
  assign window_len_out        = wlen_q;

endmodule

// File: doc/phy_idelay_tap_scan.md
Name: phy_idelay_tap_scan

Overview:
Training controller for the RGMII RX IDELAY chain. It sweeps the IDELAY tap from 0 to 31 and qualifies each tap against received preamble/SFD bytes. It finds the longest contiguous passing window and loads the tap at the window centre. It sits between the IDELAYCTRL/IDELAYE2 wrapper (ld/ce/inc/counter readback) and the PHY RX byte path, replacing the free-running checker.

Parameters:
GOOD_FRAMES, 4, consecutive good frames required for a tap to pass
MIN_PRE, 6, minimum 0x55 bytes before 0xD5 for a frame to count as good
SETTLE_CYCLES, 16, wait after every tap change before readback and checking
TIMEOUT_W, 16, per-tap timeout counter width; the tap fails at 2^TIMEOUT_W-1 cycles without a verdict

Ports:
phy_rx_clk  in  1  single clock; also drives the IDELAY C input
sys_rst  in  1  asynchronous, active-low reset
train_start_in  in  1  one-cycle pulse that (re)starts training; ignored while busy
idelayctrl_rdy_in  in  1  IDELAYCTRL ready
idelay_ld_out  out  1  load tap to 0
idelay_ce_out  out  1  tap increment enable
idelay_inc_out  out  1  increment direction, held 1 whenever ce asserts
idelay_counter_value_in  in  5  IDELAY CNTVALUEOUT readback
phy_rxd_in  in  8  RX byte, post-IDDR
phy_rvalid_in  in  1  RX byte valid
train_busy_out  out  1  training in progress
train_done_out  out  1  level; training finished (pass or fail)
train_fail_out  out  1  level; no passing tap found, or readback mismatch
tap_value_out  out  5  final applied tap
window_len_out  out  6  length of best window (0..32)

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset is honoured mid-training. Outputs leave reset and then stay at 0 until the first start pulse.
- States: IDLE -> WAIT_RDY -> LOAD -> SETTLE -> CHECK -> (STEP -> SETTLE -> CHECK)* -> EVAL -> APPLY_LD -> APPLY_INC -> VERIFY -> DONE.
- IDLE: train_start_in moves to WAIT_RDY. The start pulse clears done and fail, and sets busy in the next cycle.
- WAIT_RDY: wait for idelayctrl_rdy_in=1.
- Ready loss: idelayctrl_rdy_in=0 in any busy state returns the FSM to WAIT_RDY. The sweep, bitmap and best-window registers all clear.
- LOAD: idelay_ld_out=1 for exactly 1 cycle; expected tap = 0.
- STEP: idelay_ce_out=1 and idelay_inc_out=1 for exactly 1 cycle; expected tap increments.
- SETTLE: count SETTLE_CYCLES, then compare idelay_counter_value_in with the expected tap. A mismatch sets train_fail_out and goes to DONE.
- CHECK, frame parser:
  - A frame already active on entry (rvalid=1) is ignored until rvalid falls.
  - A frame starts on a 0->1 edge of rvalid.
  - 0x55 bytes increment the preamble count (saturates at 15).
  - 0xD5 with count >= MIN_PRE gives a good frame.
  - Any other byte, 0xD5 too early, or rvalid falling before a verdict gives a bad frame.
  - After a verdict, remaining bytes are ignored until rvalid falls.
- Tap verdict:
  - Pass: GOOD_FRAMES consecutive good frames.
  - Fail: the first bad frame, or timeout.
  - The timeout counter resets on entry to CHECK.
- Window tracking, updated per verdict:
  - Run start/length counters.
  - On a fail, or at tap 31, the current run closes.
  - The best run is replaced only if strictly longer, so ties keep the lower start.
- After the verdict for tap 31 go to EVAL; otherwise go to STEP.
- EVAL:
  - best_len=0: set fail, tap_value_out=0, go to APPLY_LD (leaves tap 0).
  - Otherwise: centre = best_start + ((best_len-1)>>1), floor.
- APPLY_LD: 1-cycle ld.
- APPLY_INC: issue centre ce pulses, one every cycle.
- VERIFY: wait SETTLE_CYCLES, then check readback == centre. A mismatch sets fail.
- DONE:
  - done=1, busy=0.
  - tap_value_out and window_len_out are held until the next start pulse.
  - A start pulse in DONE restarts training.
- Widths: the tap counter is 5 bits and never wraps (the sweep stops at 31). The run/len counters are 6 bits.
- ld and ce are never asserted in the same cycle.

Decomposition:
- Shared package phy_idelay_pkg: FSM state enum, TAP_W=5, TAP_MAX=31, PRE_BYTE=8'h55, SFD_BYTE=8'hD5.
- One sub-module, phy_preamble_checker: frame parser emitting a good/bad verdict pulse with an arm/clear input. Used in CHECK.

Test Plan:
- Pass window 10..20 (data model corrupts other taps) -> 32 tap verdicts, ld once, ce 31 times in sweep; final tap 15, window_len 11, done=1, fail=0.
- Two windows, 3..6 and 20..23 (tie) -> tap 4, window_len 4.
- Window 25..31 (open at top) -> closes at tap 31; tap 28, window_len 7.
- No passing tap -> fail=1, done=1, tap 0, window_len 0, readback 0.
- idelayctrl_rdy_in dropped at tap 12 for 50 cycles -> sweep restarts from LOAD; final result identical to clean run; start pulse during busy ignored.
- Frame-parser edges at MIN_PRE=6:
  - 5x 0x55 + 0xD5 -> bad.
  - Frame in progress at CHECK entry -> ignored.
  - No frames -> tap fails at timeout of 65535 cycles.
  - Readback model stuck at 0 -> fail after the first STEP settle.
